piezo_arbiter: RTL and testbench

Shares the single piezo buzzer between up to N_SRC sound requesters (intro siren, effect sounds, melodies), each presenting an enable and a half-period pitch value. A strict-priority arbiter with a minimum-hold rule and an inter-sound silence gap picks one source; a tone generator then turns the granted pitch into the square wave that drives the piezo pin. It sits between the sound-producing players and the top-level piezo output, clocked by the 50 MHz system clock and paced by the 1 ms tick from sys_base.

---
 rtl/snd_pkg.sv | 19 +
 rtl/piezo_tone_gen.sv | 37 +++
 rtl/piezo_arbiter.sv | 121 ++++++++++++
 tb/tb_piezo_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/snd_pkg.sv
// Shared sound-subsystem definitions: arbiter FSM encoding, pitch width,
// system clock rate and a half-period helper for building pitch tables.
package snd_pkg;

   localparam int unsigned CLK_HZ  = 50_000_000;
   localparam int          PITCH_W = 32;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } snd_state_t;

   // Half-period in clk cycles for a tone of f_hz.
   function automatic int unsigned half_period(input int unsigned f_hz);
      return CLK_HZ / (2 * f_hz);
   endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: toggles every latched_pitch clks, re-sampling the
// pitch only at half-period boundaries so live pitch sweeps stay glitch-free.
module piezo_tone_gen
   import snd_pkg::*;
#(
   parameter int PW = PITCH_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          enable,
   input  logic [PW-1:0] pitch,
   output logic          square
);

   logic [PW-1:0] cnt;
   logic [PW-1:0] lat;

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt    <= '0;
         lat    <= '0;
         square <= 1'b0;
      end else if (!enable || lat == '0) begin
         // idle or zero pitch: keep silent and track the source pitch each clk
         cnt    <= '0;
         lat    <= pitch;
         square <= 1'b0;
      end else if (cnt >= lat - PW'(1)) begin
         cnt    <= '0;
         lat    <= pitch;
         square <= ~square;
      end else begin
         cnt    <= cnt + PW'(1);
      end
   end

endmodule

// File: rtl/piezo_arbiter.sv
// Strict-priority piezo arbiter with minimum hold and inter-sound gap.
// Optional PIEZO_ARB_MUTE_EN adds i_mute, which silences the pin without
// disturbing arbitration.
module piezo_arbiter
   import snd_pkg::*;
#(
   parameter int N_SRC       = 3,
   parameter int PW          = PITCH_W,
   parameter int GAP_MS      = 20,
   parameter int MIN_HOLD_MS = 50
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                i_tick,
   input  logic [N_SRC-1:0]    i_req_en,
   input  logic [N_SRC*PW-1:0] i_req_pitch,
   output logic [N_SRC-1:0]    o_grant,
   output logic                o_busy,
   output logic                o_piezo
`ifdef PIEZO_ARB_MUTE_EN
   ,
   input  logic                i_mute
`endif
);

   localparam int HW = $clog2(MIN_HOLD_MS + 2);
   localparam int GW = $clog2(GAP_MS + 2);

   snd_state_t       state, state_n;
   logic [N_SRC-1:0] grant, grant_n, pri;
   logic [HW-1:0]    hold_cnt, hold_n;
   logic [GW-1:0]    gap_cnt, gap_n;
   logic [PW-1:0]    tone_pitch;
   logic             mute, square, drop, higher;

`ifdef PIEZO_ARB_MUTE_EN
   assign mute = i_mute;
`else
   assign mute = 1'b0;
`endif

   always_comb begin
      pri = '0;
      for (int k = N_SRC - 1; k >= 0; k--)
         if (i_req_en[k]) begin
            pri    = '0;
            pri[k] = 1'b1;
         end
   end

   // grant-1 on a one-hot vector masks exactly the higher-priority sources
   assign drop   = ~|(grant & i_req_en);
   assign higher = |(i_req_en & (grant - N_SRC'(1)));

   always_comb begin
      state_n = state;
      grant_n = grant;
      hold_n  = hold_cnt;
      gap_n   = gap_cnt;
      unique case (state)
         ST_IDLE: if (|i_req_en) begin
            state_n = ST_PLAY;
            grant_n = pri;
            hold_n  = '0;
         end
         ST_PLAY: begin
            if (i_tick && hold_cnt < HW'(MIN_HOLD_MS)) hold_n = hold_cnt + HW'(1);
            if (drop || (higher && hold_cnt >= HW'(MIN_HOLD_MS))) begin
               state_n = ST_GAP;
               grant_n = '0;
               hold_n  = '0;
               gap_n   = '0;
            end
         end
         ST_GAP: begin
            if (gap_cnt == GW'(GAP_MS)) begin
               gap_n   = '0;
               grant_n = pri;
               state_n = (|i_req_en) ? ST_PLAY : ST_IDLE;
            end else if (i_tick) begin
               gap_n = gap_cnt + GW'(1);
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         grant    <= '0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
      end else begin
         state    <= state_n;
         grant    <= grant_n;
         hold_cnt <= hold_n;
         gap_cnt  <= gap_n;
      end
   end

   // Pitch follows the next grant so the latch is primed on the grant edge.
   always_comb begin
      tone_pitch = '0;
      for (int k = 0; k < N_SRC; k++)
         if (grant_n[k]) tone_pitch = i_req_pitch[k*PW +: PW];
   end

   piezo_tone_gen #(.PW(PW)) u_tone (
      .clk    (clk),
      .rst    (rst),
      .enable (|grant && !mute),
      .pitch  (tone_pitch),
      .square (square)
   );

   assign o_grant = grant;
   assign o_busy  = (state != ST_IDLE);
   assign o_piezo = square & (|grant) & ~mute;

endmodule

// File: tb/tb_piezo_arbiter.sv
// Directed bench for piezo_arbiter: N_SRC=3, GAP_MS=2, MIN_HOLD_MS=3,
// one tick every 10 clks. Mute checks compile only with PIEZO_ARB_MUTE_EN.
module tb_piezo_arbiter;

   localparam int N  = 3;
   localparam int PW = 32;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            i_tick = 1'b0;
   logic [N-1:0]    i_req_en = '0;
   logic [N*PW-1:0] i_req_pitch = '0;
   logic [N-1:0]    o_grant;
   logic            o_busy;
   logic            o_piezo;
`ifdef PIEZO_ARB_MUTE_EN
   logic            i_mute = 1'b0;
`endif

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;

   piezo_arbiter #(.N_SRC(N), .PW(PW), .GAP_MS(2), .MIN_HOLD_MS(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .i_tick      (i_tick),
      .i_req_en    (i_req_en),
      .i_req_pitch (i_req_pitch),
      .o_grant     (o_grant),
      .o_busy      (o_busy),
      .o_piezo     (o_piezo)
`ifdef PIEZO_ARB_MUTE_EN
      ,
      .i_mute      (i_mute)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
      end
   endtask

   // One clk: inputs change 1 ns after the edge; tick is pending every 10th edge.
   task automatic cyc1();
      @(posedge clk);
      #1;
      cyc++;
      i_tick = (cyc % 10 == 0);
   endtask

   task automatic cycn(input int n);
      for (int i = 0; i < n; i++) cyc1();
   endtask

   // Advance until the edge that registers the next tick has passed.
   task automatic tick_edge();
      int n = 0;
      while (!i_tick && n < 20) begin
         cyc1();
         n++;
      end
      if (n >= 20) begin
         nmis++;
         $display("FAIL tick_timeout: got no tick within %0d clks", n);
      end else begin
         cyc1();
      end
   endtask

   task automatic set_pitch(input int k, input logic [PW-1:0] v);
      i_req_pitch[k*PW +: PW] = v;
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      i_req_en = '0;
      cycn(2);
      rst = 1'b0;
   endtask

   initial begin
      logic seen_high;

      // reset state
      cycn(3);
      chk("rst_grant", {29'd0, o_grant}, 32'h0);
      chk("rst_busy",  {31'd0, o_busy},  32'h0);
      chk("rst_piezo", {31'd0, o_piezo}, 32'h0);
      rst = 1'b0;
      cyc1();

      // source 1, pitch 4: grant after 1 clk, rise at +4, period 8
      set_pitch(1, 4);
      i_req_en = 3'b010;
      cyc1();
      chk("t1_grant", {29'd0, o_grant}, 32'h2);
      chk("t1_busy",  {31'd0, o_busy},  32'h1);
      cycn(3);
      chk("t1_p3",  {31'd0, o_piezo}, 32'h0);
      cyc1();
      chk("t1_p4",  {31'd0, o_piezo}, 32'h1);
      cycn(3);
      chk("t1_p7",  {31'd0, o_piezo}, 32'h1);
      cyc1();
      chk("t1_p8",  {31'd0, o_piezo}, 32'h0);
      cycn(4);
      chk("t1_p12", {31'd0, o_piezo}, 32'h1);

      // drop: silent next clk, gap of 2 ticks, then idle
      i_req_en = 3'b000;
      cyc1();
      chk("t1_drop_grant", {29'd0, o_grant}, 32'h0);
      chk("t1_drop_piezo", {31'd0, o_piezo}, 32'h0);
      tick_edge();
      tick_edge();
      chk("t1_gap_busy", {31'd0, o_busy}, 32'h1);
      cyc1();
      chk("t1_idle_busy", {31'd0, o_busy}, 32'h0);

      // source 2 playing, source 0 arrives at hold=1: preempt only after hold=3
      do_reset();
      set_pitch(2, 6);
      set_pitch(0, 5);
      i_req_en = 3'b100;
      cyc1();
      chk("t2_grant", {29'd0, o_grant}, 32'h4);
      tick_edge();
      i_req_en = 3'b101;
      tick_edge();
      cycn(3);
      chk("t2_nopre", {29'd0, o_grant}, 32'h4);
      tick_edge();
      cyc1();
      chk("t2_pre_grant", {29'd0, o_grant}, 32'h0);
      chk("t2_pre_busy",  {31'd0, o_busy},  32'h1);
      tick_edge();
      tick_edge();
      chk("t2_gap_grant", {29'd0, o_grant}, 32'h0);
      chk("t2_gap_piezo", {31'd0, o_piezo}, 32'h0);
      cyc1();
      chk("t2_new_grant", {29'd0, o_grant}, 32'h1);

      // lower priority never preempts; drop with lower pending goes via gap
      do_reset();
      set_pitch(1, 4);
      i_req_en = 3'b010;
      cyc1();
      i_req_en = 3'b110;
      for (int i = 0; i < 4; i++) tick_edge();
      chk("t3_lowpri", {29'd0, o_grant}, 32'h2);
      i_req_en = 3'b100;
      cyc1();
      chk("t3_drop", {29'd0, o_grant}, 32'h0);
      tick_edge();
      tick_edge();
      chk("t3_gap", {29'd0, o_grant}, 32'h0);
      cyc1();
      chk("t3_grant2", {29'd0, o_grant}, 32'h4);

      // pitch 0 stays silent; then 8 -> 4 change at counter 2
      do_reset();
      set_pitch(0, 0);
      i_req_en = 3'b001;
      cyc1();
      seen_high = 1'b0;
      for (int i = 0; i < 20; i++) begin
         cyc1();
         seen_high |= o_piezo;
      end
      chk("t4_p0_silent", {31'd0, seen_high}, 32'h0);
      chk("t4_p0_grant",  {29'd0, o_grant},   32'h1);
      set_pitch(0, 8);
      cycn(3);
      set_pitch(0, 4);
      cycn(5);
      chk("t4_e8",  {31'd0, o_piezo}, 32'h0);
      cyc1();
      chk("t4_e9",  {31'd0, o_piezo}, 32'h1);
      cycn(3);
      chk("t4_e12", {31'd0, o_piezo}, 32'h1);
      cyc1();
      chk("t4_e13", {31'd0, o_piezo}, 32'h0);
      cycn(4);
      chk("t4_e17", {31'd0, o_piezo}, 32'h1);

      // reset mid-play with piezo high
      rst = 1'b1;
      cyc1();
      chk("t5_grant", {29'd0, o_grant}, 32'h0);
      chk("t5_busy",  {31'd0, o_busy},  32'h0);
      chk("t5_piezo", {31'd0, o_piezo}, 32'h0);
      rst = 1'b0;
      i_req_en = '0;
      cyc1();

`ifdef PIEZO_ARB_MUTE_EN
      // mute silences without dropping grant; unmute restarts from counter 0
      set_pitch(1, 4);
      i_req_en = 3'b010;
      cyc1();
      cycn(4);
      chk("t6_pre", {31'd0, o_piezo}, 32'h1);
      i_mute = 1'b1;
      cyc1();
      chk("t6_mute_piezo", {31'd0, o_piezo}, 32'h0);
      chk("t6_mute_grant", {29'd0, o_grant}, 32'h2);
      cycn(5);
      chk("t6_mute_hold", {31'd0, o_piezo}, 32'h0);
      i_mute = 1'b0;
      cycn(3);
      chk("t6_un3", {31'd0, o_piezo}, 32'h0);
      cyc1();
      chk("t6_un4", {31'd0, o_piezo}, 32'h1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
